// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter
// Lets several requesters share one character-LCD write path (the
// controller's start/done byte interface). Requests are arbitrated
// round-robin. The winner's byte and RS flag are latched and handed to the
// controller. After the controller reports done, a settling delay runs so
// the HD44780-style panel can finish the write. Only then does the owner
// receive a one-cycle acknowledge.

module lcd_write_arbiter #(
    parameter int                N_REQ      = 4,
    parameter int                DLY_W      = 18,
    parameter logic [DLY_W-1:0]  DLY_CYCLES = 18'h3FFFE
) (
    input  logic                 iCLK,
    input  logic                 iRST_N,
    input  logic [N_REQ-1:0]     iReq,
    input  logic [8*N_REQ-1:0]   iData,
    input  logic [N_REQ-1:0]     iRS,
    output logic [N_REQ-1:0]     oGrant,
    output logic [N_REQ-1:0]     oAck,
    output logic                 oBusy,
    output logic                 oStart,
    output logic [7:0]           oData,
    output logic                 oRS,
    input  logic                 iDone
);

    localparam int               PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DELAY = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [PTR_W-1:0]   r_ptr;      // highest-priority requester for the next arbitration
    logic [PTR_W-1:0]   r_owner;    // requester owning the transfer in flight
    logic [DLY_W-1:0]   r_cnt;      // settling-delay counter
    logic [N_REQ-1:0]   r_grant;
    logic [N_REQ-1:0]   r_ack;
    logic               r_busy;
    logic               r_start;
    logic [7:0]         r_data;
    logic               r_rs;

    logic               w_found;
    logic [PTR_W-1:0]   w_win;
    logic [PTR_W-1:0]   w_next_ptr;

    // Round-robin pick: first asserted request at or after r_ptr, wrapping.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] cand;
        // NOTE: every variable gets a value before the loop so no path leaves
        // it unassigned; otherwise synthesis would infer a latch.
        w_found = 1'b0;
        w_win   = '0;
        idx     = 0;
        cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx  = (int'(r_ptr) + k) % N_REQ;
            cand = PTR_W'(idx);
            if (!w_found && iReq[cand]) begin
                w_found = 1'b1;
                w_win   = cand;
            end
        end
    end

    // Pointer moves to the requester just after the owner, wrapping at N_REQ.
    always_comb begin
        w_next_ptr = (r_owner == LAST_IDX) ? '0 : r_owner + PTR_W'(1);
    end

    // Transfer sequencer: IDLE -> START -> DELAY -> DONE, outputs registered.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        // NOTE: every register is cleared on reset, including the latched
        // byte. A reset in the middle of a transfer must drop all outputs at
        // once, and no acknowledge may follow.
        if (!iRST_N) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_cnt   <= '0;
            r_grant <= '0;
            r_ack   <= '0;
            r_busy  <= 1'b0;
            r_start <= 1'b0;
            r_data  <= '0;
            r_rs    <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments. Every register then
            // updates from the values it held before the edge, whatever the
            // statement order.
            case (r_state)
                ST_IDLE: begin
                    r_ack <= '0;
                    if (w_found) begin
                        // Request and payload are sampled only here.
                        r_owner <= w_win;
                        r_grant <= ONE_HOT0 << w_win;
                        r_data  <= iData[{w_win, 3'b000} +: 8];
                        r_rs    <= iRS[w_win];
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ST_START;
                    end
                end

                ST_START: begin
                    // Hold start and payload until the controller reports done.
                    if (iDone) begin
                        r_start <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_DELAY;
                    end
                end

                ST_DELAY: begin
                    // DLY_CYCLES+1 clocks of settling time; grant stays held.
                    if (r_cnt == DLY_CYCLES) begin
                        r_cnt   <= '0;
                        r_grant <= '0;
                        r_ack   <= ONE_HOT0 << r_owner;
                        r_ptr   <= w_next_ptr;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + DLY_W'(1);
                    end
                end

                ST_DONE: begin
                    // Acknowledge lasts exactly this one cycle.
                    r_ack   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign oGrant = r_grant;
    assign oAck   = r_ack;
    assign oBusy  = r_busy;
    assign oStart = r_start;
    assign oData  = r_data;
    assign oRS    = r_rs;

endmodule

// File: doc/lcd_write_arbiter.md
Name: lcd_write_arbiter

Overview:
- Shares the single character-LCD write path (the LCD_Controller start/done byte interface) between N_REQ independent requesters, e.g. a text-refresh engine, a debug/status writer and a command/init sequencer.
- Arbitrates round-robin, latches the winner's byte and RS flag, and drives the controller's start/done handshake.
- Enforces the post-write settling delay the HD44780-style panel needs.
- Returns a one-cycle acknowledge to the winning requester.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DLY_W, 18, width of the settling-delay counter.
- DLY_CYCLES, 18'h3FFFE, settling-delay terminal count; DELAY state lasts DLY_CYCLES+1 clocks.

Ports:
- iCLK  in  1  system clock; all logic is on its rising edge.
- iRST_N  in  1  asynchronous active-low reset.
- iReq  in  N_REQ  per-requester write request, level.
- iData  in  8*N_REQ  requester i byte on bits [8i+7:8i].
- iRS  in  N_REQ  requester i register select: 1 = data, 0 = command.
- oGrant  out  N_REQ  one-hot, marks the requester owning the current transfer.
- oAck  out  N_REQ  one-cycle pulse to the owner when its transfer and delay are complete.
- oBusy  out  1  high whenever the FSM is not IDLE.
- oStart  out  1  to controller iStart.
- oData  out  8  to controller iDATA.
- oRS  out  1  to controller iRS.
- iDone  in  1  from controller oDone.

Behaviour:
- Reset (async, iRST_N=0): state IDLE; oGrant, oAck, oBusy, oStart, oData, oRS = 0; round-robin pointer = 0; delay counter = 0. Reset asserted mid-transfer aborts it immediately, with no oAck.
- All outputs are registered.
- State IDLE:
  - If any iReq bit is set, the winner is the first set bit found scanning from the pointer upward, wrapping modulo N_REQ.
  - On that edge: latch oData/oRS from the winner's slice, set oGrant to the winner, set oStart=1 and oBusy=1, go to START.
  - Latency: iReq sampled high at edge k gives oStart high after edge k.
- State START:
  - Hold oStart=1 and hold oData/oRS stable until iDone is sampled high.
  - On that edge: oStart=0, counter=0, go to DELAY.
  - No timeout.
- State DELAY:
  - Counter increments each clock.
  - When counter == DLY_CYCLES: counter=0, go to DONE.
  - oGrant stays held throughout.
- State DONE (one cycle):
  - oAck[winner]=1 for exactly this cycle; oGrant=0.
  - Pointer = (winner+1) mod N_REQ.
  - oBusy=0 on the following edge; go to IDLE.
- Request rules:
  - iReq and iData/iRS are sampled only in IDLE; changes during START/DELAY/DONE are ignored.
  - A requester that drops iReq after grant still completes and receives oAck.
  - A requester must deassert iReq in the cycle after oAck. Otherwise it is treated as a new request and competes normally, at lowest priority because the pointer has advanced.
- Fairness: with all requesters continuously asserting, grants rotate 0,1,…,N_REQ-1,0,…
- Throughput: one transfer occupies 1 (IDLE) + controller time + DLY_CYCLES+1 + 1 (DONE) clocks minimum.
- iDone is ignored outside START. An iDone already high on entry to START completes START on the next edge.
- Invariants: oGrant is zero or one-hot; oAck is a one-hot pulse or zero; oStart is never high outside START.

Test Plan (DLY_CYCLES=4, N_REQ=4, controller model asserts iDone 3 clocks after oStart):
- Reset mid-DELAY with iReq=4'b0001 active → all outputs 0 immediately, no oAck, pointer=0; after release, requester 0 is re-granted.
- Single request iReq=4'b0100, iData[23:16]=8'h41, iRS[2]=1 → oStart next cycle with oData=8'h41, oRS=1, oGrant=4'b0100. oAck=4'b0100 pulses once exactly 5 clocks after iDone is sampled. Then oBusy=0.
- All four requesting continuously, each deasserting for one cycle after its oAck → grant order 0,1,2,3,0; each oAck is a single-cycle pulse.
- Requester 1 drops iReq and changes iData during START → oData holds the latched value, transfer completes, oAck[1] still pulses.
- iDone pulsed in IDLE and DELAY → no state change, no spurious oStart or oAck.
